// File: rtl/data_memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter_pkg
// Description : Shared types and default widths for the data-memory arbiter
//               slice. owner_t names the master that was granted last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam int c_addr_w = 64;
    localparam int c_data_w = 64;

endpackage : data_memory_arbiter_pkg
`default_nettype wire

// File: rtl/data_memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter_if
// Description : Bus bundle between the core load/store path, the DMA master,
//               the arbiter and the data_memory instance.
//               slave  : arbiter view (takes requests, drives acks and mem_*)
//               master : environment view (drives requests, memory read data)
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_arbiter_if
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
);
    // core master
    logic              core_req;
    logic              core_write;
    logic [ADDR_W-1:0] core_address;
    logic [DATA_W-1:0] core_write_data;
    logic              core_ack;
    logic [DATA_W-1:0] core_read_data;
    // dma master
    logic              dma_req;
    logic              dma_write;
    logic [ADDR_W-1:0] dma_address;
    logic [DATA_W-1:0] dma_write_data;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_read_data;
    // memory port
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  core_req, core_write, core_address, core_write_data,
        output core_ack, core_read_data,
        input  dma_req, dma_write, dma_address, dma_write_data,
        output dma_ack, dma_read_data,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output core_req, core_write, core_address, core_write_data,
        input  core_ack, core_read_data,
        output dma_req, dma_write, dma_address, dma_write_data,
        input  dma_ack, dma_read_data,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data
    );

endinterface : data_memory_arbiter_if
`default_nettype wire

// File: rtl/data_memory_arbiter_rr_burst_select.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter_rr_burst_select
// Description : Round-robin winner selection with a burst limit. Holds the
//               owner (master granted last cycle) and its consecutive-grant
//               count; produces the combinational grants for this cycle.
// Ports       : clock, reset      - clock, async active-high reset
//               core_req, dma_req - requests this cycle
//               grant_core/dma    - winner this cycle (one-hot or none)
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter_rr_burst_select
    import data_memory_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic core_req,
    input  wire logic dma_req,
    output logic      grant_core,
    output logic      grant_dma
);

    localparam int               c_cnt_w     = $clog2(MAX_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [1:0]       c_own_idle  = OWN_IDLE;
    localparam logic [1:0]       c_own_core  = OWN_CORE;
    localparam logic [1:0]       c_own_dma   = OWN_DMA;

    logic [1:0]         r_owner;
    logic [c_cnt_w-1:0] r_burst_cnt;
    logic               w_limit;
    logic [1:0]         w_winner;

    always_comb begin
        w_limit    = (r_burst_cnt >= c_max_burst);
        grant_core = 1'b0;
        grant_dma  = 1'b0;
        if (core_req && dma_req) begin
            // Under contention the owner keeps the port until its burst is
            // exhausted; an idle owner defaults to the core.
            case (r_owner)
                c_own_core: begin
                    grant_core = ~w_limit;
                    grant_dma  = w_limit;
                end
                c_own_dma: begin
                    grant_core = w_limit;
                    grant_dma  = ~w_limit;
                end
                default: grant_core = 1'b1;
            endcase
        end else begin
            grant_core = core_req;
            grant_dma  = dma_req;
        end
    end

    always_comb begin
        w_winner = c_own_idle;
        if (grant_core)
            w_winner = c_own_core;
        else if (grant_dma)
            w_winner = c_own_dma;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner     <= c_own_idle;
            r_burst_cnt <= '0;
        end else if (w_winner == c_own_idle) begin
            r_owner     <= c_own_idle;
            r_burst_cnt <= '0;
        end else if (w_winner == r_owner) begin
            if (r_burst_cnt < c_max_burst)
                r_burst_cnt <= r_burst_cnt + c_cnt_one;
        end else begin
            r_owner     <= w_winner;
            r_burst_cnt <= c_cnt_one;
        end
    end

endmodule : data_memory_arbiter_rr_burst_select
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter
// Description : Shares the single data_memory port between the core load/store
//               path and a DMA master. Zero-latency ack to the winner; the
//               loser holds its request and retries next cycle.
// Ports       : clock  - rising-edge clock
//               reset  - async active-high reset (forces acks/strobes low)
//               bus    - data_memory_arbiter_if.slave (core, dma, mem ports)
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W    = c_addr_w,
    parameter int DATA_W    = c_data_w,
    parameter int MAX_BURST = 4
) (
    input  wire logic            clock,
    input  wire logic            reset,
    data_memory_arbiter_if.slave bus
);

    logic              w_grant_core;
    logic              w_grant_dma;
    logic              w_core_ack;
    logic              w_dma_ack;
    logic [ADDR_W-1:0] w_mem_address;
    logic [DATA_W-1:0] w_mem_write_data;

    data_memory_arbiter_rr_burst_select #(
        .MAX_BURST (MAX_BURST)
    ) u_select (
        .clock      (clock),
        .reset      (reset),
        .core_req   (bus.core_req),
        .dma_req    (bus.dma_req),
        .grant_core (w_grant_core),
        .grant_dma  (w_grant_dma)
    );

    // Grants are combinational from the requests, so they must be masked
    // here to keep the memory untouched while reset is held.
    assign w_core_ack = w_grant_core & ~reset;
    assign w_dma_ack  = w_grant_dma  & ~reset;

    always_comb begin
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        w_mem_address    = '0;
        w_mem_write_data = '0;
        if (w_core_ack) begin
            bus.mem_read     = ~bus.core_write;
            bus.mem_write    = bus.core_write;
            w_mem_address    = bus.core_address;
            w_mem_write_data = bus.core_write_data;
        end else if (w_dma_ack) begin
            bus.mem_read     = ~bus.dma_write;
            bus.mem_write    = bus.dma_write;
            w_mem_address    = bus.dma_address;
            w_mem_write_data = bus.dma_write_data;
        end
    end

    assign bus.mem_address    = w_mem_address;
    assign bus.mem_write_data = w_mem_write_data;
    assign bus.core_ack       = w_core_ack;
    assign bus.dma_ack        = w_dma_ack;
    // Read data fans out to both masters; each qualifies it with its own ack.
    assign bus.core_read_data = bus.mem_read_data;
    assign bus.dma_read_data  = bus.mem_read_data;

endmodule : data_memory_arbiter
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_arbiter
// Description : Self-checking bench for data_memory_arbiter: directed table,
//               hand-written corner sequences and randomized traffic checked
//               against a behavioural model with its own memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;
    import data_memory_arbiter_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mem_init = 1'b1;

    data_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ---------------- memory behind the arbiter ----------------
    function automatic logic [63:0] seed(input int i);
        return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0000_0001_0001);
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'(a[10:3]);
    endfunction

    logic [63:0] mem [0:255];
    assign bus.mem_read_data = mem[bus.mem_address[10:3]];
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
        end else if (bus.mem_write) begin
            mem[bus.mem_address[10:3]] <= bus.mem_write_data;
        end
    end

    // ---------------- reference model ----------------
    // who: 0 none, 1 core, 2 dma
    int prev_own = 0;
    int run      = 0;
    logic [63:0] ref_mem [int];
    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        if (ref_mem.exists(widx(a))) return ref_mem[widx(a)];
        return seed(widx(a));
    endfunction

    function automatic int pick(input logic c, input logic d);
        if (!c && !d) return 0;
        if (c && !d)  return 1;
        if (d && !c)  return 2;
        if (prev_own == 0) return 1;
        if (run < MB) return prev_own;
        return 3 - prev_own;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Sample on the falling edge and compare every observable output.
    task automatic sample(input string tag, output int w);
        logic wr;
        logic [63:0] a, d;
        @(negedge clock);
        w  = reset ? 0 : pick(bus.core_req, bus.dma_req);
        wr = (w == 1) ? bus.core_write : bus.dma_write;
        a  = (w == 1) ? bus.core_address : bus.dma_address;
        d  = (w == 1) ? bus.core_write_data : bus.dma_write_data;
        chk({tag, " core_ack"}, 64'(bus.core_ack), 64'(w == 1));
        chk({tag, " dma_ack"},  64'(bus.dma_ack),  64'(w == 2));
        chk({tag, " mem_read"}, 64'(bus.mem_read),  64'(w != 0 && !wr));
        chk({tag, " mem_write"}, 64'(bus.mem_write), 64'(w != 0 && wr));
        if (!reset) begin
            chk({tag, " mem_address"},    bus.mem_address,    (w != 0) ? a : 64'd0);
            chk({tag, " mem_write_data"}, bus.mem_write_data, (w != 0) ? d : 64'd0);
        end
        if (w == 1 && !wr) chk({tag, " core_read_data"}, bus.core_read_data, ref_rd(a));
        if (w == 2 && !wr) chk({tag, " dma_read_data"},  bus.dma_read_data,  ref_rd(a));
    endtask

    task automatic advance(input int w);
        @(posedge clock);
        if (reset || w == 0) begin
            prev_own = 0;
            run      = 0;
        end else if (w == prev_own) begin
            if (run < MB) run++;
        end else begin
            prev_own = w;
            run      = 1;
        end
        if (w == 1 && bus.core_write) ref_mem[widx(bus.core_address)] = bus.core_write_data;
        if (w == 2 && bus.dma_write)  ref_mem[widx(bus.dma_address)]  = bus.dma_write_data;
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
                         input logic dr, input logic dw, input logic [63:0] da, input logic [63:0] dd);
        bus.core_req = cr; bus.core_write = cw; bus.core_address = ca; bus.core_write_data = cd;
        bus.dma_req  = dr; bus.dma_write  = dw; bus.dma_address  = da; bus.dma_write_data  = dd;
    endtask

    // Run a held-input sequence; pattern chars: C core ack, D dma ack, - none.
    task automatic run_pat(input string tag, input string pat);
        int w;
        for (int i = 0; i < pat.len(); i++) begin
            sample(tag, w);
            chk({tag, " pattern"}, {bus.core_ack, bus.dma_ack},
                (pat[i] == "C") ? 64'd2 : (pat[i] == "D") ? 64'd1 : 64'd0);
            advance(w);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        cr, cw;
        logic [63:0] ca, cd;
        logic        dr, dw;
        logic [63:0] da, dd;
        logic        e_cack, e_dack, e_mr, e_mw;
        logic [63:0] e_addr;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int w;
        string tag;

        tbl[0] = '{1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 64'h40, 64'hDEAD,
                   1'b0, 1'b1, 1'b0, 1'b1, 64'h40};
        tbl[1] = '{1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        for (int i = 2; i < 14; i++) begin
            logic c;
            c = (i < 6) || (i >= 10);
            tbl[i] = '{1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b1, 64'h80, 64'h1234,
                       c, !c, c, !c, c ? 64'h10 : 64'h80};
        end

        // Reset with both requesting: everything held low.
        drive(1, 0, 64'h18, 0, 1, 0, 64'h20, 0);
        sample("reset", w);
        advance(w);
        mem_init = 1'b0;
        sample("reset2", w);
        advance(w);
        reset = 1'b0;
        sample("post_reset", w);
        chk("post_reset first core_ack", 64'(bus.core_ack), 64'd1);
        advance(w);

        for (int i = 0; i < 14; i++) begin
            tag = $sformatf("tbl%0d", i);
            drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
                  tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
            sample(tag, w);
            chk({tag, " t_core_ack"}, 64'(bus.core_ack),  64'(tbl[i].e_cack));
            chk({tag, " t_dma_ack"},  64'(bus.dma_ack),   64'(tbl[i].e_dack));
            chk({tag, " t_mem_read"}, 64'(bus.mem_read),  64'(tbl[i].e_mr));
            chk({tag, " t_mem_write"}, 64'(bus.mem_write), 64'(tbl[i].e_mw));
            chk({tag, " t_mem_address"}, bus.mem_address, tbl[i].e_addr);
            if (i == 0) chk({tag, " t_wdata"}, bus.mem_write_data, 64'hDEAD);
            advance(w);
        end

        // Four DMA grants, then a lone core load at 0x8; the core then owns
        // with a count of one, so three more contended core grants follow.
        drive(1, 0, 64'h10, 0, 1, 1, 64'h88, 64'h5555);
        run_pat("dma_burst", "DDDD");
        drive(1, 0, 64'h8, 0, 0, 0, 0, 0);
        sample("core_only", w);
        chk("core_only read_data", bus.core_read_data, seed(1));
        advance(w);
        drive(1, 0, 64'h8, 0, 1, 0, 64'h90, 0);
        run_pat("after_core_only", "CCCD");

        // Reset pulse mid-burst: acks drop immediately, state returns to idle.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        run_pat("gap5", "-");
        drive(1, 1, 64'h30, 64'hAAAA, 1, 0, 64'h38, 0);
        run_pat("pre_reset", "CC");
        reset = 1'b1;
        #1;
        chk("async reset core_ack", 64'(bus.core_ack), 64'd0);
        chk("async reset mem_write", 64'(bus.mem_write), 64'd0);
        sample("in_reset", w);
        advance(w);
        reset = 1'b0;
        run_pat("post_pulse", "CCCCD");

        // One idle cycle between bursts clears ownership.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        run_pat("gap6a", "-");
        drive(1, 0, 64'h30, 0, 1, 0, 64'h40, 0);
        run_pat("burst6", "CCCC");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        run_pat("gap6b", "-");
        drive(1, 0, 64'h30, 0, 1, 0, 64'h40, 0);
        run_pat("after_gap", "C");

        // Randomized traffic; a loser holds its request unchanged.
        w = 1;
        for (int n = 0; n < 3000; n++) begin
            if (!bus.core_req || w == 1) begin
                bus.core_req        = ($urandom_range(0, 3) != 0);
                bus.core_write      = $urandom_range(0, 1) == 1;
                bus.core_address    = 64'($urandom_range(0, 255)) << 3;
                bus.core_write_data = {$urandom, $urandom};
            end
            if (!bus.dma_req || w == 2) begin
                bus.dma_req         = ($urandom_range(0, 3) != 0);
                bus.dma_write       = $urandom_range(0, 1) == 1;
                bus.dma_address     = 64'($urandom_range(0, 255)) << 3;
                bus.dma_write_data  = {$urandom, $urandom};
            end
            sample("rand", w);
            advance(w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_memory_arbiter
`default_nettype wire
